pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised successor of the pipeline PC register: generates fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Tracks outstanding fetches in an in-order queue and matches returning instructions to their PCs.
- Presents fetched instructions to the IF/ID boundary with freeze (stall) and branch-redirect/flush.
- Sits between the hazard/branch logic and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC and address width in bits
RESET_VEC, 0, PC value loaded on reset
INC, 4, byte increment per sequential fetch
DEPTH, 4, outstanding-fetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
freeze  in  1  stall from hazard unit; holds the if_* outputs
branch_taken  in  1  redirect request, one-cycle pulse
branch_addr  in  ADDR_W  redirect target
req_valid  out  1  fetch request valid
req_addr  out  ADDR_W  fetch address
req_ready  in  1  imem accepts request
rsp_valid  in  1  imem returns one instruction, strictly in request order
rsp_data  in  32  returned instruction
if_valid  out  1  instruction valid toward IF/ID
if_pc  out  ADDR_W  PC of presented instruction
if_instr  out  32  presented instruction
pc_out  out  ADDR_W  current fetch PC (next address to request)
count  out  $clog2(DEPTH)+1  occupied queue entries

Behaviour:
- Reset (reset==0, asynchronous):
  - pc = RESET_VEC; queue emptied (all pointers and count 0, all entry flags cleared).
  - Outputs: req_valid=1, req_addr=pc_out=RESET_VEC, if_valid=0, count=0; if_pc/if_instr = 0.
- State:
  - pc register.
  - Queue of DEPTH entries {pc, instr, filled, stale}, with push, fill and pop pointers.
- Request side:
  - req_valid = (count < DEPTH), independent of freeze and of a pop in the same cycle.
  - req_addr = pc.
  - Handshake (req_valid && req_ready): push {pc, filled=0, stale=0}.
- PC update priority:
  - branch_taken: pc <= branch_addr.
  - else handshake: pc <= pc + INC, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - else hold.
  - freeze never affects pc directly.
- Response side:
  - rsp_valid writes rsp_data into the entry at the fill pointer, sets filled, advances the fill pointer.
  - rsp_valid with no unfilled occupied entry is ignored; no state change.
- Flush:
  - On branch_taken, set stale on every occupied entry, including one pushed in the same cycle.
  - A response landing the same cycle fills the entry and it is also marked stale.
- Output (combinational from head entry, no extra register):
  - if_valid = head occupied && filled && !stale; if_pc/if_instr = head fields.
  - Minimum latency: rsp_valid at cycle N produces if_valid at cycle N+1.
- Pop:
  - if_valid && !freeze: normal consume.
  - head filled && stale: silent drop, regardless of freeze.
  - At most one pop per cycle.
- Count:
  - count = pushes − pops; push and pop in the same cycle leaves count unchanged.
  - Push is impossible when count==DEPTH, even if a pop occurs that cycle.
- Freeze:
  - if_* held stable while freeze=1 and if_valid=1.
  - Issuing continues until the queue is full; responses keep filling entries; no instruction is lost or duplicated.
- Stale guarantee: no instruction requested before a branch_taken ever appears with if_valid=1 after it.
- Mid-operation reset: flushes everything. Responses to pre-reset requests are the environment's responsibility (imem is reset together with this block).

Test Plan:
- Reset: hold reset=0 with random inputs -> pc_out=0, req_valid=1, if_valid=0, count=0; release, req_ready=1 -> req_addr 0x0, 0x4, 0x8 on consecutive cycles.
- Sequential stream: req_ready=1, rsp_valid one cycle after each request, rsp_data=0xE000_0000+n -> if_pc 0x0,0x4,0x8,… with matching instr, one per cycle, count ≤ 2.
- Freeze/backpressure: freeze=1 while if_pc=0x8 -> if_* held at 0x8; req_valid drops when count=4; release freeze -> 0x8,0xC,0x10,0x14 drained in order, then issuing resumes at pc_out=0x18.
- Branch flush: 3 entries outstanding (2 filled), branch_taken addr 0x100 -> the 3 old instructions never reach if_valid; first valid if_pc=0x100, then 0x104.
- Simultaneous events: branch_taken in the same cycle as a handshake and a rsp_valid fill, with freeze=1 -> both affected entries dropped; next if_pc=branch_addr; a second branch before the drain completes -> still no stale output.
- Wrap: RESET_VEC=0xFFFF_FFF8 -> req_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; mid-stream reset=0 -> count=0, if_valid=0 immediately (asynchronously), pc_out=RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-address generator with an in-order outstanding-fetch queue.
// Presents returned instructions to IF/ID with freeze and branch flush.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
  parameter int                INC       = 4,
  parameter int                DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     freeze,
  input  logic                     branch_taken,
  input  logic [ADDR_W-1:0]        branch_addr,
  output logic                     req_valid,
  output logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_ready,
  input  logic                     rsp_valid,
  input  logic [31:0]              rsp_data,
  output logic                     if_valid,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [31:0]              if_instr,
  output logic [ADDR_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_C = ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] ent_pc_r    [DEPTH];
  logic [31:0]       ent_instr_r [DEPTH];
  logic [DEPTH-1:0]  filled_r;
  logic [DEPTH-1:0]  stale_r;
  logic [PTR_W-1:0]  push_ptr_r;
  logic [PTR_W-1:0]  fill_ptr_r;
  logic [PTR_W-1:0]  pop_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  pend_r;

  logic push_s;
  logic fill_s;
  logic pop_s;
  logic occupied_s;
  logic head_filled_s;
  logic head_stale_s;

  // Handshake, fill and pop decisions plus the head-of-queue presentation.
  always_comb begin
    occupied_s    = (count_r != CNT_ZERO);
    head_filled_s = filled_r[pop_ptr_r];
    head_stale_s  = stale_r[pop_ptr_r];
    req_valid     = (count_r < DEPTH_C);
    push_s        = req_valid && req_ready;
    // pend_r counts requested-but-unanswered entries; a response without one is dropped
    fill_s        = rsp_valid && (pend_r != CNT_ZERO);
    if_valid      = occupied_s && head_filled_s && !head_stale_s;
    pop_s         = occupied_s && head_filled_s && (head_stale_s || !freeze);
    if_pc         = ent_pc_r[pop_ptr_r];
    if_instr      = ent_instr_r[pop_ptr_r];
    req_addr      = pc_r;
    pc_out        = pc_r;
    count         = count_r;
  end

  // Fetch PC: redirect beats sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_VEC;
    end else if (branch_taken) begin
      pc_r <= branch_addr;
    end else if (push_s) begin
      pc_r <= pc_r + INC_C;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Queue pointers, occupancy and outstanding-response counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_ptr_r <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      pop_ptr_r  <= {PTR_W{1'b0}};
      count_r    <= CNT_ZERO;
      pend_r     <= CNT_ZERO;
    end else begin
      if (push_s) push_ptr_r <= push_ptr_r + PTR_ONE;
      if (fill_s) fill_ptr_r <= fill_ptr_r + PTR_ONE;
      if (pop_s)  pop_ptr_r  <= pop_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case ({push_s, fill_s})
        2'b10:   pend_r <= pend_r + CNT_ONE;
        2'b01:   pend_r <= pend_r - CNT_ONE;
        default: pend_r <= pend_r;
      endcase
    end
  end

  // Entry storage; a branch marks every slot stale, a fresh push inherits the branch flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_r[i]    <= {ADDR_W{1'b0}};
        ent_instr_r[i] <= 32'h0000_0000;
        filled_r[i]    <= 1'b0;
        stale_r[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_s && (push_ptr_r == PTR_W'(i))) begin
          ent_pc_r[i] <= pc_r;
          filled_r[i] <= 1'b0;
          stale_r[i]  <= branch_taken;
        end else begin
          if (fill_s && (fill_ptr_r == PTR_W'(i))) begin
            ent_instr_r[i] <= rsp_data;
            filled_r[i]    <= 1'b1;
          end
          if (branch_taken) stale_r[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, freeze, branch_taken, req_ready, rsp_valid;
  logic [31:0] branch_addr, rsp_data;
  logic        req_valid, if_valid;
  logic [31:0] req_addr, if_pc, if_instr, pc_out;
  logic [2:0]  count;

  logic        w_reset, w_freeze, w_branch, w_ready, w_rsp_valid;
  logic [31:0] w_baddr, w_rsp_data;
  logic        w_req_valid, w_if_valid;
  logic [31:0] w_req_addr, w_if_pc, w_if_instr, w_pc_out;
  logic [2:0]  w_count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
    bit          stale;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] obs[$];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .pc_out(pc_out), .count(count)
  );

  pc_fetch_unit #(.RESET_VEC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(w_reset), .freeze(w_freeze), .branch_taken(w_branch),
    .branch_addr(w_baddr), .req_valid(w_req_valid), .req_addr(w_req_addr),
    .req_ready(w_ready), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr),
    .pc_out(w_pc_out), .count(w_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: one clock edge applied to the fetch queue.
  task automatic model_step();
    bit   push, pop, found;
    int   idx;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_pc = 32'h0;
    end else begin
      push  = (mq.size() < 4) && req_ready;
      pop   = (mq.size() > 0) && mq[0].filled && (mq[0].stale || !freeze);
      found = 1'b0;
      idx   = 0;
      if (rsp_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!found && !mq[i].filled) begin
            found = 1'b1;
            idx   = i;
          end
        end
        if (found) begin
          e = mq[idx];
          e.filled = 1'b1;
          e.instr  = rsp_data;
          mq[idx]  = e;
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = m_pc; e.instr = 32'h0; e.filled = 1'b0; e.stale = 1'b0;
        mq.push_back(e);
      end
      if (branch_taken) begin
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          e.stale = 1'b1;
          mq[i] = e;
        end
        m_pc = branch_addr;
      end else if (push) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model();
    bit exp_v;
    chk("req_valid", req_valid, mq.size() < 4);
    chk("req_addr", req_addr, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("count", count, mq.size());
    exp_v = 1'b0;
    if (mq.size() > 0) exp_v = mq[0].filled && !mq[0].stale;
    chk("if_valid", if_valid, exp_v);
    if (exp_v) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].instr);
    end
    if (if_valid) obs.push_back(if_pc);
  endtask

  task automatic cyc(input bit f, input bit bt, input logic [31:0] ba,
                     input bit rdy, input bit rv, input logic [31:0] rd);
    freeze = f; branch_taken = bt; branch_addr = ba;
    req_ready = rdy; rsp_valid = rv; rsp_data = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    w_reset = 1'b0; w_freeze = 1'b1; w_branch = 1'b0; w_baddr = 32'h0;
    w_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    mq.delete();
    m_pc = 32'h0;

    // Reset held with random inputs
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_req_valid", req_valid, 1'b1);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
    end

    // Sequential stream, response one cycle after each request
    reset = 1'b1;
    chk("seq_addr0", req_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, k >= 1, 32'hE000_0000 + k - 1);
      chk("seq_addr", req_addr, 32'(4 * (k + 1)));
      chk("seq_count_le2", count <= 3'd2, 1'b1);
      if (k >= 1) begin
        chk("seq_if_valid", if_valid, 1'b1);
        chk("seq_if_pc", if_pc, 32'(4 * (k - 1)));
        chk("seq_if_instr", if_instr, 32'hE000_0000 + k - 1);
      end
    end

    // Freeze while 0x8 is presented; queue fills to DEPTH
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE000_0003);
    chk("frz_hold_pc", if_pc, 32'h8);
    chk("frz_hold_valid", if_valid, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE000_0004);
    chk("frz_full_req_valid", req_valid, 1'b0);
    chk("frz_full_count", count, 3'd4);
    chk("frz_full_pc_out", pc_out, 32'h18);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE000_0005);
    chk("frz_hold_pc2", if_pc, 32'h8);
    chk("frz_hold_instr", if_instr, 32'hE000_0002);
    for (int j = 0; j < 4; j++) begin
      chk("drain_pc", if_pc, 32'h8 + 32'(4 * j));
      chk("drain_instr", if_instr, 32'hE000_0002 + j);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    chk("drain_count", count, 3'd0);
    chk("drain_pc_out", pc_out, 32'h18);

    // Branch flush with three outstanding entries, two filled
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0000);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0001);
    chk("flush_pre_count", count, 3'd3);
    obs.delete();
    cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0002);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0001);
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("flush_obs_len", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("flush_first_pc", obs[0], 32'h100);
      chk("flush_second_pc", obs[1], 32'h104);
    end

    // Branch + handshake + fill under freeze, then a second branch mid-drain
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    obs.delete();
    cyc(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'hB000_0000);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'hB000_0001);
    chk("sim_count", count, 3'd3);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0002);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0003);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0004);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0005);
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("sim_obs_len", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("sim_first_pc", obs[0], 32'h300);
      chk("sim_second_pc", obs[1], 32'h304);
    end
    chk("sim_pc_out", pc_out, 32'h308);

    // Randomized traffic including occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom);
    end
    reset = 1'b1;

    // Wrap-around from a high reset vector, then an asynchronous mid-stream reset
    @(negedge clk);
    chk("wrap_addr0", w_req_addr, 32'hFFFF_FFF8);
    w_reset = 1'b1;
    w_ready = 1'b1;
    @(negedge clk);
    chk("wrap_addr1", w_req_addr, 32'hFFFF_FFFC);
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    chk("wrap_addr2", w_req_addr, 32'h0000_0000);
    chk("wrap_count", w_count, 3'd2);
    chk("wrap_if_valid", w_if_valid, 1'b1);
    chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFF8);
    chk("wrap_if_instr", w_if_instr, 32'h1234_5678);
    w_rsp_valid = 1'b0;
    #2;
    w_reset = 1'b0;
    #1;
    chk("arst_count", w_count, 3'd0);
    chk("arst_if_valid", w_if_valid, 1'b0);
    chk("arst_pc_out", w_pc_out, 32'hFFFF_FFF8);
    chk("arst_req_valid", w_req_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
